// File: rtl/bin2bcd_disp.sv
// bin2bcd_disp: sequential double-dabble binary-to-BCD converter feeding a 4-digit display.
// Optional macro BIN2BCD_OVF_SAT_EN: overflow shows 9999 instead of EEEE.
module bin2bcd_disp #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_value,
  input  logic [1:0]       in_decplace,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [1:0]       decplace,
  output logic             overflow,
  output logic             out_valid
);
`ifdef BIN2BCD_OVF_SAT_EN
  localparam logic [15:0] ovf_pat = 16'h9999;
`else
  localparam logic [15:0] ovf_pat = 16'hEEEE;
`endif
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [15:0]      bcd, bcd_adj;
  logic [4:0]       cnt;
  logic [1:0]       dp;
  logic             ovf, ovf_in;
  assign in_ready = state == IDLE;
  // Always false for WIDTH < 14, since such values cannot exceed 9999
  assign ovf_in = 32'(in_value) > 32'd9999;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      dp        <= '0;
      ovf       <= 1'b0;
      {digit3, digit2, digit1, digit0} <= '0;
      decplace  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          shift <= in_value;
          bcd   <= '0;
          dp    <= in_decplace;
          ovf   <= ovf_in;
          cnt   <= 5'(WIDTH);
          state <= CONV;
        end
        CONV: begin
          {bcd, shift} <= {bcd_adj, shift} << 1;
          cnt          <= cnt - 5'd1;
          if (cnt == 5'd1) state <= LOAD;
        end
        LOAD: begin
          {digit3, digit2, digit1, digit0} <= ovf ? ovf_pat : bcd;
          decplace  <= dp;
          overflow  <= ovf;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bin2bcd_disp.sv
// tb_bin2bcd_disp: scoreboard bench for bin2bcd_disp with directed vectors.
module tb_bin2bcd_disp;
`ifdef BIN2BCD_OVF_SAT_EN
  localparam logic [15:0] ovp = 16'h9999;
`else
  localparam logic [15:0] ovp = 16'hEEEE;
`endif
  typedef struct {
    logic [15:0] d;
    logic [1:0]  dp;
    logic        o;
    int          acc;
  } exp_t;
  logic        clk = 0, rst_n = 1;
  logic [13:0] in_value = '0;
  logic [1:0]  in_decplace = '0;
  logic        in_valid = 0;
  logic        in_ready, overflow, out_valid;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic [1:0]  decplace;
  exp_t        q[$];
  int          cyc = 0, checks = 0, errors = 0;
  int          a1, a2;
  bin2bcd_disp #(.WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_decplace(in_decplace),
    .in_valid(in_valid), .in_ready(in_ready), .digit0(digit0), .digit1(digit1),
    .digit2(digit2), .digit3(digit3), .decplace(decplace), .overflow(overflow),
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("digits", {digit3, digit2, digit1, digit0}, e.d);
        chk("decplace", decplace, e.dp);
        chk("overflow", overflow, e.o);
        chk("latency", cyc - e.acc, 15);
        chk("ready_in_out_cycle", in_ready, 1);
      end
    end
  end
  task automatic send(input int v, input int dp, input logic [15:0] d, input bit o,
                      input bit hold, output int acc);
    bit rdy = 0;
    acc = 0;
    @(negedge clk);
    in_value = 14'(v);
    in_decplace = 2'(dp);
    in_valid = 1;
    for (int n = 0; n < 100 && !rdy; n++) begin
      if (n != 0) @(negedge clk);
      rdy = in_ready;
      acc = cyc + 1;
      @(posedge clk);
    end
    chk("accept_timeout", int'(rdy), 1);
    if (rdy) q.push_back('{d, 2'(dp), o, acc});
    if (!hold) begin
      @(negedge clk);
      in_valid = 0;
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("result_timeout", q.size(), 0);
    repeat (20) @(negedge clk);
  endtask
  initial begin
    int a;
    #2 rst_n = 0;
    #1;
    chk("rst_digits", {digit3, digit2, digit1, digit0}, 0);
    chk("rst_decplace", decplace, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    send(1234, 2, 16'h1234, 0, 0, a); wait_done();
    send(0, 0, 16'h0000, 0, 0, a); wait_done();
    send(10000, 3, ovp, 1, 0, a); wait_done();
    send(16383, 1, ovp, 1, 0, a); wait_done();
    send(9999, 1, 16'h9999, 0, 0, a); wait_done();
    // Busy: a second request during conversion must be ignored
    send(42, 2, 16'h0042, 0, 0, a);
    in_value = 14'd77;
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      chk("busy_ready", in_ready, 0);
      chk("busy_hold_digits", {digit3, digit2, digit1, digit0}, 16'h9999);
      chk("busy_hold_decplace", decplace, 1);
      @(negedge clk);
    end
    in_valid = 0;
    wait_done();
    // Back-to-back with in_valid held high
    send(5, 1, 16'h0005, 0, 1, a1);
    send(8, 1, 16'h0008, 0, 0, a2);
    chk("b2b_period", a2 - a1, 16);
    wait_done();
    // Reset mid-conversion
    send(4321, 3, 16'h4321, 0, 0, a);
    repeat (6) @(posedge clk);
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("midrst_digits", {digit3, digit2, digit1, digit0}, 0);
    chk("midrst_decplace", decplace, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    chk("midrst_no_result", {digit3, digit2, digit1, digit0}, 0);
    send(4321, 3, 16'h4321, 0, 0, a); wait_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
